// File: rtl/pic_fetch_unit.sv
// pic_fetch_unit: instruction-fetch front end for the 14-bit PIC-style core.
// Owns the program counter and the circular return stack. GOTO, CALL,
// RETURN and RETLW are resolved from the combinational ROM word in the
// same cycle, so redirects cost no bubble.
//
// Execute-stage interaction:
//   stall_in = 1 : every register in this unit holds; skip_in is ignored.
//   skip_in  = 1 : the word in ir_out is a taken skip. It only has effect
//                  while ir_valid = 1 and stall_in = 0. The word being
//                  fetched this cycle becomes a bubble and has no effect
//                  on the PC or the stack. The execute stage keeps skip_in
//                  asserted across any stall until it is consumed.
module pic_fetch_unit #(
   parameter int                  PC_WIDTH     = 11,
   parameter int                  STACK_DEPTH  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic [PC_WIDTH-1:0] Rom_addr_out,
   input  logic [13:0]         Rom_data_in,
   input  logic                stall_in,
   input  logic                skip_in,
   output logic [13:0]         ir_out,
   output logic                ir_valid,
   output logic [PC_WIDTH-1:0] ir_pc,
   output logic                stack_overflow,
   output logic                stack_underflow
);

   localparam int SP_W    = $clog2(STACK_DEPTH);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

   // Architectural state
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
   logic [SP_W-1:0]     sp;
   logic [DEPTH_W-1:0]  depth;

   // Decode of the word currently presented by the ROM
   logic                is_goto;
   logic                is_call;
   logic                is_return;
   logic                is_retlw;
   logic [PC_WIDTH-1:0] target;

   // Control for this cycle
   logic                advance;
   logic                skip_now;
   logic                do_push;
   logic                do_pop;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [SP_W-1:0]     pop_idx;
   logic [PC_WIDTH-1:0] pop_data;
   logic [PC_WIDTH-1:0] next_pc;
   logic                stack_full;
   logic                stack_empty;

   assign Rom_addr_out = pc;

   // Opcode classification and branch target from the fetched word
   always_comb begin
      is_goto   = (Rom_data_in[13:11] == 3'b101);
      is_call   = (Rom_data_in[13:11] == 3'b100);
      is_return = (Rom_data_in == 14'h0008);
      is_retlw  = (Rom_data_in[13:10] == 4'b1101);
      target    = Rom_data_in[PC_WIDTH-1:0];
   end

   // Cycle qualification: whether the fetched word takes effect, and stack ops
   always_comb begin
      advance     = !stall_in;
      skip_now    = skip_in && ir_valid;
      do_push     = !reset && advance && !skip_now && is_call;
      do_pop      = !reset && advance && !skip_now && (is_return || is_retlw);
      pc_inc      = pc + 1'b1;
      pop_idx     = sp - 1'b1;
      pop_data    = stack_mem[pop_idx];
      stack_full  = (depth == DEPTH_MAX);
      stack_empty = (depth == '0);
   end

   // Next-PC selection; the skip path always falls through to PC+1
   always_comb begin
      next_pc = pc_inc;
      if (!skip_now) begin
         if (is_goto || is_call) begin
            next_pc = target;
         end else if (is_return || is_retlw) begin
            next_pc = pop_data;
         end
      end
   end

   // PC and instruction register, frozen by stall
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_VECTOR;
         ir_out   <= 14'h0000;
         ir_valid <= 1'b0;
         ir_pc    <= '0;
      end else if (advance) begin
         pc    <= next_pc;
         ir_pc <= pc;
         if (skip_now) begin
            ir_out   <= 14'h0000;
            ir_valid <= 1'b0;
         end else begin
            ir_out   <= Rom_data_in;
            ir_valid <= 1'b1;
         end
      end
   end

   // Stack pointer, depth counter and sticky error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         sp              <= '0;
         depth           <= '0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else if (do_push) begin
         sp <= sp + 1'b1;
         if (stack_full) begin
            stack_overflow <= 1'b1;
         end else begin
            depth <= depth + 1'b1;
         end
      end else if (do_pop) begin
         sp <= pop_idx;
         if (stack_empty) begin
            stack_underflow <= 1'b1;
         end else begin
            depth <= depth - 1'b1;
         end
      end
   end

   // Return-address storage; a push at full depth overwrites the oldest entry
   always_ff @(posedge clk) begin
      if (do_push) begin
         stack_mem[sp] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_pic_fetch_unit.sv
// tb_pic_fetch_unit: directed bench for pic_fetch_unit with a behavioural
// reference model of the fetch rules and a per-cycle compare process.
module tb_pic_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_in;
   logic        skip_in;
   logic [10:0] Rom_addr_out;
   logic [13:0] Rom_data_in;
   logic [13:0] ir_out;
   logic        ir_valid;
   logic [10:0] ir_pc;
   logic        stack_overflow;
   logic        stack_underflow;

   logic [13:0] rom [2048];

   int n_cmp  = 0;
   int n_fail = 0;
   bit armed  = 1'b0;

   // Reference model state
   logic [10:0] m_pc;
   logic [13:0] m_ir;
   logic        m_valid;
   logic [10:0] m_irpc;
   logic [10:0] m_stack [8];
   int          m_sp;
   int          m_depth;
   logic        m_ovf;
   logic        m_unf;

   pic_fetch_unit #(
      .PC_WIDTH    (11),
      .STACK_DEPTH (8),
      .RESET_VECTOR(11'h000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .Rom_addr_out   (Rom_addr_out),
      .Rom_data_in    (Rom_data_in),
      .stall_in       (stall_in),
      .skip_in        (skip_in),
      .ir_out         (ir_out),
      .ir_valid       (ir_valid),
      .ir_pc          (ir_pc),
      .stack_overflow (stack_overflow),
      .stack_underflow(stack_underflow)
   );

   // Clock and combinational program ROM
   always #5 clk = ~clk;
   assign Rom_data_in = rom[Rom_addr_out];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: one instruction-fetch step per rising edge
   always @(posedge clk) begin
      logic [13:0] w;
      armed = 1'b1;
      if (reset) begin
         m_pc = 11'h000; m_ir = 14'h0000; m_valid = 1'b0; m_irpc = 11'h000;
         m_sp = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (!stall_in) begin
         w = rom[m_pc];
         m_irpc = m_pc;
         if (skip_in && m_valid) begin
            m_ir = 14'h0000; m_valid = 1'b0;
            m_pc = m_pc + 11'd1;
         end else begin
            m_ir = w; m_valid = 1'b1;
            if (w ==? 14'b10_1???????????) begin
               m_pc = w[10:0];
            end else if (w ==? 14'b10_0???????????) begin
               if (m_depth == 8) m_ovf = 1'b1;
               m_stack[m_sp] = m_pc + 11'd1;
               m_sp = (m_sp + 1) % 8;
               if (m_depth < 8) m_depth++;
               m_pc = w[10:0];
            end else if (w == 14'h0008 || (w ==? 14'b11_01??????????)) begin
               if (m_depth == 0) m_unf = 1'b1;
               m_sp = (m_sp + 7) % 8;
               m_pc = m_stack[m_sp];
               if (m_depth > 0) m_depth--;
            end else begin
               m_pc = m_pc + 11'd1;
            end
         end
      end
   end

   // Compare process: every output against the model, away from the active edge
   always @(negedge clk) begin
      if (armed) begin
         chk("model.rom_addr", Rom_addr_out, m_pc);
         chk("model.ir_out", ir_out, m_ir);
         chk("model.ir_valid", ir_valid, m_valid);
         chk("model.ir_pc", ir_pc, m_irpc);
         chk("model.overflow", stack_overflow, m_ovf);
         chk("model.underflow", stack_underflow, m_unf);
      end
   end

   // Driver tasks
   task automatic clear_rom();
      for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall_in = 1'b0; skip_in = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic step(input int n, input logic st, input logic sk);
      reset = 1'b0; stall_in = st; skip_in = sk;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".addr"}, Rom_addr_out, 11'h000);
      chk({tag, ".ir_out"}, ir_out, 14'h0000);
      chk({tag, ".ir_valid"}, ir_valid, 1'b0);
      chk({tag, ".ir_pc"}, ir_pc, 11'h000);
      chk({tag, ".ovf"}, stack_overflow, 1'b0);
      chk({tag, ".unf"}, stack_underflow, 1'b0);
   endtask

   // Nested-call program: GOTO 0x40, CALL chain with stride 2, RETURNs between
   task automatic load_call_chain();
      clear_rom();
      rom[0] = 14'h2840;
      for (int i = 0; i < 9; i++) begin
         rom[11'h40 + 2 * i] = 14'h2000 | 14'(11'h40 + 2 * (i + 1));
         rom[11'h41 + 2 * i] = 14'h0008;
      end
      rom[11'h52] = 14'h3455;
   endtask

   // Timeline of the call chain starting from the reset state
   task automatic run_call_chain(input string tag);
      step(1, 0, 0);
      chk({tag, ".goto"}, Rom_addr_out, 11'h040);
      step(8, 0, 0);
      chk({tag, ".pc8"}, Rom_addr_out, 11'h050);
      chk({tag, ".ovf8"}, stack_overflow, 1'b0);
      step(1, 0, 0);
      chk({tag, ".pc9"}, Rom_addr_out, 11'h052);
      chk({tag, ".ovf9"}, stack_overflow, 1'b1);
      step(1, 0, 0);
      chk({tag, ".retlw_pc"}, Rom_addr_out, 11'h051);
      chk({tag, ".retlw_ir"}, ir_out, 14'h3455);
      step(7, 0, 0);
      chk({tag, ".pop8_pc"}, Rom_addr_out, 11'h043);
      chk({tag, ".unf8"}, stack_underflow, 1'b0);
      step(1, 0, 0);
      chk({tag, ".pop9_pc"}, Rom_addr_out, 11'h051);
      chk({tag, ".unf9"}, stack_underflow, 1'b1);
      step(6, 0, 0);
      chk({tag, ".ovf_sticky"}, stack_overflow, 1'b1);
      chk({tag, ".unf_sticky"}, stack_underflow, 1'b1);
   endtask

   // Directed scenarios
   initial begin
      reset = 1'b1; stall_in = 1'b0; skip_in = 1'b0;

      // Linear fetch
      clear_rom();
      rom[0] = 14'h01A5; rom[1] = 14'h0103; rom[2] = 14'h3001; rom[3] = 14'h00A5;
      do_reset();
      chk_reset_state("lin.rst");
      step(1, 0, 0);
      chk("lin.c1.addr", Rom_addr_out, 11'h001);
      chk("lin.c1.ir", ir_out, 14'h01A5);
      chk("lin.c1.pc", ir_pc, 11'h000);
      chk("lin.c1.valid", ir_valid, 1'b1);
      step(1, 0, 0);
      chk("lin.c2.addr", Rom_addr_out, 11'h002);
      chk("lin.c2.ir", ir_out, 14'h0103);
      step(1, 0, 0);
      chk("lin.c3.ir", ir_out, 14'h3001);
      step(1, 0, 0);
      chk("lin.c4.addr", Rom_addr_out, 11'h004);
      chk("lin.c4.ir", ir_out, 14'h00A5);
      chk("lin.c4.pc", ir_pc, 11'h003);

      // CALL/RETURN, skip, GOTO, stall
      clear_rom();
      rom[11'h00] = 14'h2808; rom[11'h08] = 14'h2012; rom[11'h12] = 14'h0008;
      rom[11'h09] = 14'h1FA5; rom[11'h0A] = 14'h2805; rom[11'h0C] = 14'h2814;
      rom[11'h14] = 14'h0103;
      do_reset();
      step(1, 0, 1);
      chk("cr.skip_ignored.addr", Rom_addr_out, 11'h008);
      chk("cr.skip_ignored.ir", ir_out, 14'h2808);
      step(1, 0, 0);
      chk("cr.call.addr", Rom_addr_out, 11'h012);
      step(1, 0, 0);
      chk("cr.ret.addr", Rom_addr_out, 11'h009);
      chk("cr.ret.valid", ir_valid, 1'b1);
      step(1, 0, 0);
      chk("cr.ir_1fa5", ir_out, 14'h1FA5);
      step(1, 0, 1);
      chk("skip.ir", ir_out, 14'h0000);
      chk("skip.valid", ir_valid, 1'b0);
      chk("skip.ir_pc", ir_pc, 11'h00A);
      chk("skip.addr", Rom_addr_out, 11'h00B);
      step(1, 0, 1);
      chk("skip2.valid", ir_valid, 1'b1);
      chk("skip2.addr", Rom_addr_out, 11'h00C);
      step(1, 0, 0);
      chk("goto14.addr", Rom_addr_out, 11'h014);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1);
         chk("stall.addr", Rom_addr_out, 11'h014);
         chk("stall.ir", ir_out, 14'h2814);
         chk("stall.ir_pc", ir_pc, 11'h00C);
      end
      step(1, 0, 1);
      chk("unstall.addr", Rom_addr_out, 11'h015);
      chk("unstall.valid", ir_valid, 1'b0);
      step(1, 0, 0);
      chk("resume.addr", Rom_addr_out, 11'h016);

      // Same program without the skip: GOTO loop back to 05
      do_reset();
      step(4, 0, 0);
      chk("loop.addr_0a", Rom_addr_out, 11'h00A);
      step(1, 0, 0);
      chk("loop.goto05", Rom_addr_out, 11'h005);
      chk("loop.ir", ir_out, 14'h2805);
      step(5, 0, 0);
      chk("loop.ret09", Rom_addr_out, 11'h009);
      chk("loop.ovf", stack_overflow, 1'b0);
      chk("loop.unf", stack_underflow, 1'b0);
      step(12, 0, 0);

      // Overflow / underflow
      load_call_chain();
      do_reset();
      run_call_chain("ovf1");

      // Reset while a CALL is fetched at depth 3
      do_reset();
      chk_reset_state("mid.rst0");
      step(1, 0, 0);
      step(3, 0, 0);
      chk("mid.pre.addr", Rom_addr_out, 11'h046);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_state("mid.rst");
      run_call_chain("ovf2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
